// File: rtl/servo_move_scheduler.sv
// ============================================================================
// servo_move_scheduler: FIFO-buffered timed move playback for the servo controller
// Rev 1.0
// ============================================================================
`default_nettype none

module servo_move_scheduler #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000,
    parameter int DUR_W    = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd_dir,
    input  logic [DUR_W-1:0]         cmd_dur_ms,
    output logic                     cmd_ready,
    input  logic                     abort,
    output logic [2:0]               direction,
    output logic                     useServo,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     done_pulse
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(TICK_DIV - 1);
    localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [DUR_W+2:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]   ms_q, ms_d, cur_dur_q, cur_dur_d;
    logic [2:0]         dir_q, dir_d;
    logic               use_q, use_d, done_q, done_d;

    logic               w_push, w_pop, w_full;
    logic [DUR_W+2:0]   w_head;
    logic [2:0]         w_head_dir;
    logic [DUR_W-1:0]   w_head_dur;

    assign w_full     = (count_q == FULL_COUNT);
    assign cmd_ready  = !w_full && !abort;
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = (state_q == S_LOAD) && !abort;
    assign w_head     = mem_q[rd_ptr_q];
    // Undefined direction codes are played back as stop.
    assign w_head_dir = (w_head[DUR_W+2:DUR_W] > 3'd4) ? 3'd0 : w_head[DUR_W+2:DUR_W];
    assign w_head_dur = w_head[DUR_W-1:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {cmd_dir, cmd_dur_ms};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        ms_d      = ms_q;
        cur_dur_d = cur_dur_q;
        dir_d     = dir_q;
        use_d     = 1'b0;
        done_d    = 1'b0;
        if (abort) begin
            state_d = S_STOP;
            pre_d   = '0;
            ms_d    = '0;
            dir_d   = 3'd0;
            use_d   = 1'b1;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) state_d = S_LOAD;
                end
                S_LOAD: begin
                    cur_dur_d = w_head_dur;
                    if (w_head_dur == '0) begin
                        if (count_d != '0) begin
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_STOP;
                            dir_d   = 3'd0;
                            use_d   = 1'b1;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = S_RUN;
                        dir_d   = w_head_dir;
                        use_d   = 1'b1;
                        pre_d   = '0;
                        ms_d    = '0;
                    end
                end
                S_RUN: begin
                    if (pre_q == PRE_MAX) begin
                        pre_d = '0;
                        ms_d  = ms_q + DUR_W'(1);
                        if (ms_q == cur_dur_q - DUR_W'(1)) begin
                            if (count_q != '0) begin
                                state_d = S_LOAD;
                            end else begin
                                state_d = S_STOP;
                                dir_d   = 3'd0;
                                use_d   = 1'b1;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            pre_q     <= '0;
            ms_q      <= '0;
            cur_dur_q <= '0;
            dir_q     <= 3'd0;
            use_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            pre_q     <= pre_d;
            ms_q      <= ms_d;
            cur_dur_q <= cur_dur_d;
            dir_q     <= dir_d;
            use_q     <= use_d;
            done_q    <= done_d;
        end
    end

    assign direction   = dir_q;
    assign useServo    = use_q;
    assign done_pulse  = done_q;
    assign queue_count = count_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

`default_nettype wire
